// File: rtl/mux_sel_arbiter8_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux-select arbiter.
package mux_sel_arbiter8_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter8_rr_pick8.sv
// Combinational round-robin pick: first set request scanning from ptr upward, modulo 8.
module rr_pick8
    import mux_sel_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // 3-bit addition wraps 7 back to 0 for free.
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter8.sv
// Round-robin arbiter for an 8:1 mux: registered select code and one-hot grant,
// grants held while requested, with optional forced rotation after MAX_HOLD cycles.
module mux_sel_arbiter8
    import mux_sel_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_next;
    logic [SEL_W-1:0]  ptr, ptr_next;
    logic [SEL_W-1:0]  owner, owner_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [N_REQ-1:0]  gnt_next;
    logic [SEL_W-1:0]  sel_next;

    logic [N_REQ-1:0]  pick_req;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              owner_req;
    logic              limit_hit;

    // While granted, the owner is excluded and the scan starts just past it, which is
    // exactly the pointer value a release or pre-emption would store.
    assign pick_req  = (state == GRANT) ? (req & ~onehot(owner)) : req;
    assign pick_ptr  = (state == GRANT) ? owner + 3'd1 : ptr;
    assign owner_req = req[owner];
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

    rr_pick8 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        hold_next  = hold_cnt;
        gnt_next   = gnt;
        sel_next   = sel;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = GRANT;
                    gnt_next   = onehot(pick_idx);
                    sel_next   = pick_idx;
                    owner_next = pick_idx;
                    hold_next  = 4'd1;
                end
            end
            GRANT: begin
                if (!owner_req || (limit_hit && pick_found)) begin
                    ptr_next = owner + 3'd1;
                    if (pick_found) begin
                        gnt_next   = onehot(pick_idx);
                        sel_next   = pick_idx;
                        owner_next = pick_idx;
                        hold_next  = 4'd1;
                    end else begin
                        // sel is left alone so the mux output stays stable while idle.
                        state_next = IDLE;
                        gnt_next   = '0;
                        hold_next  = '0;
                    end
                end else if (hold_cnt < HOLD_LIM) begin
                    hold_next = hold_cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            owner    <= owner_next;
            hold_cnt <= hold_next;
            gnt      <= gnt_next;
            sel      <= sel_next;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_mux_sel_arbiter8.sv
// Directed bench for mux_sel_arbiter8: per-cycle vector table plus reset and no-pre-emption sequences.
module tb_mux_sel_arbiter8;

    logic       clk;
    logic       reset;
    logic [7:0] req4, req0;
    logic [7:0] gnt4, gnt0;
    logic [2:0] sel4, sel0;
    logic       busy4, busy0;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t tbl [N_VEC];

    mux_sel_arbiter8 #(.MAX_HOLD(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .req   (req4),
        .gnt   (gnt4),
        .sel   (sel4),
        .busy  (busy4)
    );

    mux_sel_arbiter8 #(.MAX_HOLD(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .gnt   (gnt0),
        .sel   (sel0),
        .busy  (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [7:0] g, input logic [2:0] s, input logic b);
        chk({tag, ".gnt"}, gnt4, g);
        chk({tag, ".sel"}, {5'b0, sel4}, {5'b0, s});
        chk({tag, ".busy"}, {7'b0, busy4}, {7'b0, b});
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step4(input logic [7:0] r);
        @(negedge clk);
        req4 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        req4   = 8'h00;
        req0   = 8'h00;

        // Wrap-around pre-emption, single requester, back-to-back release.
        tbl[0]  = '{8'h81, 8'h01, 3'd0, 1'b1};
        tbl[1]  = '{8'h81, 8'h01, 3'd0, 1'b1};
        tbl[2]  = '{8'h81, 8'h01, 3'd0, 1'b1};
        tbl[3]  = '{8'h81, 8'h01, 3'd0, 1'b1};
        tbl[4]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[5]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[6]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[7]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[8]  = '{8'h81, 8'h01, 3'd0, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        tbl[10] = '{8'h20, 8'h20, 3'd5, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 3'd5, 1'b0};
        tbl[12] = '{8'h04, 8'h04, 3'd2, 1'b1};
        tbl[13] = '{8'h4C, 8'h04, 3'd2, 1'b1};
        tbl[14] = '{8'h48, 8'h08, 3'd3, 1'b1};
        tbl[15] = '{8'h40, 8'h40, 3'd6, 1'b1};
        tbl[16] = '{8'h40, 8'h40, 3'd6, 1'b1};
        tbl[17] = '{8'h00, 8'h00, 3'd6, 1'b0};

        // Reset with all requests high, then first grant to index 0.
        @(negedge clk);
        reset = 1'b1;
        req4  = 8'hFF;
        #1;
        chk4("rst_hold", 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        chk4("rst_edge", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk4("rst_first", 8'h01, 3'd0, 1'b1);

        req4 = 8'h00;
        do_reset();
        for (int i = 0; i < N_VEC; i++) begin
            step4(tbl[i].req);
            chk4($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy);
        end

        // Asynchronous reset between edges drops the grant immediately.
        req4 = 8'h00;
        do_reset();
        step4(8'h10);
        chk4("ar_pre", 8'h10, 3'd4, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk4("ar_async", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req4  = 8'h30;
        @(posedge clk);
        #1;
        chk4("ar_after", 8'h10, 3'd4, 1'b1);

        // MAX_HOLD=0: owner 0 is never pre-empted.
        req4 = 8'h00;
        do_reset();
        @(negedge clk);
        req0 = 8'h03;
        @(posedge clk);
        #1;
        chk("nh_first.gnt", gnt0, 8'h01);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nh_hold%0d.gnt", i), gnt0, 8'h01);
        end
        @(negedge clk);
        req0 = 8'h02;
        @(posedge clk);
        #1;
        chk("nh_rel.gnt", gnt0, 8'h02);
        chk("nh_rel.sel", {5'b0, sel0}, 8'h01);
        chk("nh_rel.busy", {7'b0, busy0}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
